// File: rtl/gen_gpi_capture.sv
// rtl/gen_gpi_capture.sv - synchronized, debounced, edge-latched GPI bank with Avalon-MM register access
module gen_gpi_capture #(
  parameter int          WIDTH           = 32,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] RESET_LEVEL     = 32'h0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpi_in,
  input  logic [1:0]       avmm_address,
  input  logic             avmm_read,
  input  logic             avmm_write,
  input  logic [31:0]      avmm_writedata,
  output logic [31:0]      avmm_readdata,
  output logic             irq,
  output logic [WIDTH-1:0] gpi_level
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RST_LVL = RESET_LEVEL[WIDTH-1:0];

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] gpi_sync;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [31:0]      rd_mux;

  assign wdata_w   = avmm_writedata[WIDTH-1:0];
  assign rise_clr  = (avmm_write && avmm_address == 2'd1) ? wdata_w : '0;
  assign fall_clr  = (avmm_write && avmm_address == 2'd2) ? wdata_w : '0;
  assign gpi_level = level;

  // A bit must disagree with the current level for DEBOUNCE_CYCLES straight cycles to flip it.
  always_comb begin
    level_next = level;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (gpi_sync[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = ~level[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avmm_address)
      2'd0:    rd_mux[WIDTH-1:0] = level;
      2'd1:    rd_mux[WIDTH-1:0] = rise;
      2'd2:    rd_mux[WIDTH-1:0] = fall;
      default: rd_mux[WIDTH-1:0] = irq_mask;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q1       <= RST_LVL;
      gpi_sync      <= RST_LVL;
      level         <= RST_LVL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      rise          <= '0;
      fall          <= '0;
      irq_mask      <= '0;
      irq           <= 1'b0;
      avmm_readdata <= '0;
    end else begin
      sync_q1  <= gpi_in;
      gpi_sync <= sync_q1;
      level    <= level_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      // A new edge in the same cycle as its W1C keeps the latch set.
      rise     <= (rise & ~rise_clr) | (level_next & ~level);
      fall     <= (fall & ~fall_clr) | (~level_next & level);
      if (avmm_write && avmm_address == 2'd3) irq_mask <= wdata_w;
      irq      <= |((rise | fall) & irq_mask);
      // The mux sees pre-write register values, so read+write returns the old data.
      if (avmm_read) avmm_readdata <= rd_mux;
    end
  end

endmodule
